// File: rtl/turn_seq_ctrl.sv
// Sequential turn-signal and hazard-flasher controller.
// Lamps fill outward one step at a time while a side is requested.
module turn_seq_ctrl #(
    parameter int LAMPS = 3,
    parameter int DWELL = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    output logic             error,
    output logic [LAMPS-1:0] left_signal,
    output logic [LAMPS-1:0] right_signal
);

    localparam int STEP_W  = (LAMPS > 1) ? $clog2(LAMPS + 1) : 1;
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [STEP_W-1:0]  STEP_MAX   = STEP_W'(LAMPS);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEFT   = 3'd1;
    localparam logic [2:0] S_RIGHT  = 3'd2;
    localparam logic [2:0] S_HAZARD = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [STEP_W-1:0]  step_q,  step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               phase_q, phase_d;

    logic       enter;
    logic [2:0] target;
    logic       step_end;
    logic       phase_end;
    logic       active_req;

    function automatic logic [2:0] pick(input logic h, input logic l, input logic r);
        if (h)           return S_HAZARD;
        else if (l && r) return S_ERROR;
        else if (l)      return S_LEFT;
        else if (r)      return S_RIGHT;
        else             return S_IDLE;
    endfunction

    // Step 0 is a single-cycle blank step; all other steps and phases last DWELL cycles.
    assign step_end   = (step_q == '0) || (dwell_q == DWELL_LAST);
    assign phase_end  = (dwell_q == DWELL_LAST);
    assign active_req = (state_q == S_LEFT) ? left : right;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        phase_d = phase_q;
        enter   = 1'b0;
        target  = S_IDLE;

        case (state_q)
            S_IDLE: begin
                enter  = 1'b1;
                target = pick(hazard, left, right);
            end
            S_LEFT, S_RIGHT: begin
                if (!step_end) begin
                    dwell_d = dwell_q + 1'b1;
                end else if (hazard) begin
                    enter  = 1'b1;
                    target = S_HAZARD;
                end else if (left && right) begin
                    enter  = 1'b1;
                    target = S_ERROR;
                end else if (active_req) begin
                    step_d  = (step_q == STEP_MAX) ? '0 : step_q + 1'b1;
                    dwell_d = '0;
                end else begin
                    // A lone opposite-side request still passes through IDLE.
                    enter  = 1'b1;
                    target = S_IDLE;
                end
            end
            S_HAZARD: begin
                if (!phase_end) begin
                    dwell_d = dwell_q + 1'b1;
                end else if (hazard) begin
                    phase_d = ~phase_q;
                    dwell_d = '0;
                end else begin
                    enter  = 1'b1;
                    target = pick(1'b0, left, right);
                end
            end
            S_ERROR: begin
                enter  = 1'b1;
                target = pick(hazard, left && right, 1'b0);
                if (!hazard && left && right) target = S_ERROR;
                else if (!hazard)             target = S_IDLE;
            end
            default: begin
                enter  = 1'b1;
                target = S_IDLE;
            end
        endcase

        if (enter) begin
            state_d = target;
            step_d  = '0;
            dwell_d = '0;
            phase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            dwell_q <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            phase_q <= phase_d;
        end
    end

    // Lamp decode looks only at registered state, so reset blanks the lamps at once.
    always_comb begin
        error        = 1'b0;
        left_signal  = '0;
        right_signal = '0;
        case (state_q)
            S_LEFT: begin
                for (int i = 0; i < LAMPS; i++)
                    left_signal[i] = (i < int'(step_q));
            end
            S_RIGHT: begin
                for (int i = 0; i < LAMPS; i++)
                    right_signal[i] = (i >= LAMPS - int'(step_q));
            end
            S_HAZARD: begin
                if (!phase_q) begin
                    left_signal  = '1;
                    right_signal = '1;
                end
            end
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_turn_seq_ctrl.sv
// Bench for turn_seq_ctrl: two parameterisations driven by shared inputs,
// compared each cycle against a countdown-based behavioural model.
module tb_turn_seq_ctrl;

    logic clk;
    logic reset_n;
    logic left, right, hazard;

    logic       err0, err1;
    logic [2:0] ls0, rs0;
    logic [3:0] ls1, rs1;

    turn_seq_ctrl u0 (
        .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
        .error(err0), .left_signal(ls0), .right_signal(rs0)
    );

    turn_seq_ctrl #(.LAMPS(4), .DWELL(2)) u1 (
        .clk(clk), .reset_n(reset_n), .left(left), .right(right), .hazard(hazard),
        .error(err1), .left_signal(ls1), .right_signal(rs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3, M_ERR = 4;

    int LMP [2] = '{3, 4};
    int DW  [2] = '{3, 2};
    int md  [2];
    int stp [2];
    int rem [2];
    bit off [2];

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            md[n] = M_IDLE; stp[n] = 0; rem[n] = 0; off[n] = 1'b0;
        end
    endtask

    task automatic model_decide(input int n, input bit h, input bit l, input bit r);
        if (h) begin
            md[n] = M_HAZ; off[n] = 1'b0; rem[n] = DW[n];
        end else if (l && r) begin
            md[n] = M_ERR;
        end else if (l || r) begin
            md[n] = l ? M_LEFT : M_RIGHT; stp[n] = 0; rem[n] = 1;
        end else begin
            md[n] = M_IDLE;
        end
    endtask

    task automatic model_step(input int n, input bit h, input bit l, input bit r);
        bit act;
        case (md[n])
            M_IDLE: model_decide(n, h, l, r);
            M_LEFT, M_RIGHT: begin
                act = (md[n] == M_LEFT) ? l : r;
                if (rem[n] > 1) rem[n]--;
                else if (h || (l && r)) model_decide(n, h, l, r);
                else if (act) begin
                    stp[n] = (stp[n] == LMP[n]) ? 0 : stp[n] + 1;
                    rem[n] = (stp[n] == 0) ? 1 : DW[n];
                end else md[n] = M_IDLE;
            end
            M_HAZ: begin
                if (rem[n] > 1) rem[n]--;
                else if (h) begin off[n] = !off[n]; rem[n] = DW[n]; end
                else model_decide(n, 1'b0, l, r);
            end
            default: begin
                if (h) model_decide(n, 1'b1, l, r);
                else if (!(l && r)) md[n] = M_IDLE;
            end
        endcase
    endtask

    function automatic int exp_left(input int n);
        if (md[n] == M_LEFT) return (1 << stp[n]) - 1;
        if (md[n] == M_HAZ && !off[n]) return (1 << LMP[n]) - 1;
        return 0;
    endfunction

    function automatic int exp_right(input int n);
        if (md[n] == M_RIGHT) return ((1 << stp[n]) - 1) << (LMP[n] - stp[n]);
        if (md[n] == M_HAZ && !off[n]) return (1 << LMP[n]) - 1;
        return 0;
    endfunction

    task automatic check_all();
        check_eq("u0.left_signal",  int'(ls0),  exp_left(0));
        check_eq("u0.right_signal", int'(rs0),  exp_right(0));
        check_eq("u0.error",        int'(err0), (md[0] == M_ERR) ? 1 : 0);
        check_eq("u1.left_signal",  int'(ls1),  exp_left(1));
        check_eq("u1.right_signal", int'(rs1),  exp_right(1));
        check_eq("u1.error",        int'(err1), (md[1] == M_ERR) ? 1 : 0);
    endtask

    task automatic cycle(input bit l, input bit r, input bit h);
        check_all();
        left = l; right = r; hazard = h;
        model_step(0, h, l, r);
        model_step(1, h, l, r);
        @(negedge clk);
    endtask

    task automatic async_reset();
        check_all();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
    endtask

    // Directed segments: {left,right,hazard} held for the given cycle count.
    logic [2:0] seg_in  [14] = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b100, 3'b110, 3'b100,
                                 3'b000, 3'b100, 3'b101, 3'b101, 3'b100, 3'b000, 3'b010};
    int         seg_len [14] = '{25, 3, 12, 2, 3, 4, 3, 2, 6, 1, 20, 8, 3, 7};

    bit cl, cr, ch;

    initial begin
        reset_n = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset_n = 1'b1;

        for (int s = 0; s < 14; s++)
            for (int c = 0; c < seg_len[s]; c++)
                cycle(seg_in[s][2], seg_in[s][1], seg_in[s][0]);

        async_reset();
        for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 1'b0);

        cl = 0; cr = 0; ch = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(11) == 0) cl = !cl;
            if ($urandom_range(19) == 0) cr = !cr;
            if ($urandom_range(39) == 0) ch = !ch;
            if (c % 400 == 217) async_reset();
            cycle(cl, cr, ch);
        end
        check_all();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/turn_seq_ctrl.md
TURN_SEQ_CTRL -- requirements
Module: turn_seq_ctrl

Interface
REQ-001 The block SHALL have parameter LAMPS, default 3, lamps per side; legal range 1..8.
REQ-002 The block SHALL have parameter DWELL, default 3, clock cycles each lit step is held; legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port left  input  1  left turn request.
REQ-006 The block SHALL have port right  input  1  right turn request.
REQ-007 The block SHALL have port hazard  input  1  hazard flasher request.
REQ-008 The block SHALL have port error  output  1  conflicting left and right requests.
REQ-009 The block SHALL have port left_signal  output  LAMPS  left lamps; bit 0 is the innermost lamp.
REQ-010 The block SHALL have port right_signal  output  LAMPS  right lamps; bit LAMPS-1 is the innermost lamp.

Function
REQ-011 Control states SHALL be IDLE, LEFT, RIGHT, HAZARD and ERROR.
- step counter: 0..LAMPS.
- dwell counter: 0..DWELL-1.
- hazard phase bit.
REQ-012 All outputs SHALL be Moore-decoded from registered state only; there SHALL be no combinational path from inputs to outputs.
REQ-013 Priority at every decision point SHALL be hazard, then (left and right) -> ERROR, then left, then right, else IDLE.
REQ-014 IDLE SHALL be a decision point on every cycle.
REQ-015 Entry to LEFT or RIGHT SHALL start at step 0.
- step 0 lasts 1 cycle.
- steps 1..LAMPS last DWELL cycles each.
REQ-016 LEFT step k SHALL drive left_signal with bits [k-1:0] set and right_signal = 0; e.g. 000, 001, 011, 111 for LAMPS=3.
REQ-017 RIGHT step k SHALL drive right_signal with bits [LAMPS-1:LAMPS-k] set and left_signal = 0; e.g. 000, 100, 110, 111 for LAMPS=3.
REQ-018 In LEFT and RIGHT, inputs SHALL be sampled only on the last cycle of each step; input changes mid-step SHALL be ignored.
REQ-019 At a step boundary where the active side's request is still asserted (and no higher-priority request), the step SHALL advance.
- step LAMPS wraps to step 0.
- sequence period is 1 + LAMPS*DWELL cycles.
REQ-020 At a step boundary where the active side's request is deasserted, the next state SHALL be IDLE. A lone opposite-side request SHALL NOT switch sides directly.
REQ-021 HAZARD SHALL always start in the ON phase.
- ON phase: all lamps on both sides lit for DWELL cycles.
- OFF phase: all lamps off for DWELL cycles.
- phases alternate.
REQ-022 In HAZARD, inputs SHALL be sampled only on the last cycle of each phase; hazard=0 there SHALL apply REQ-013 without hazard.
REQ-023 ERROR SHALL drive error=1 and all lamps off, and SHALL be a decision point on every cycle. It exits to HAZARD if hazard=1, stays while left and right are both 1, else goes to IDLE.
REQ-024 error SHALL be 0 in every state other than ERROR.
REQ-025 With defaults and hazard tied to 0, the output sequence SHALL be cycle-identical to the existing 3-lamp turn signal controller.
REQ-026 Counter widths SHALL be derived from the parameters with a 1-bit minimum; no counter SHALL exceed its legal range.
REQ-027 An unreachable state encoding SHALL return to IDLE on the next clock edge, with outputs all 0.

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, clear all counters and the phase bit, and drive error=0 with all lamps off.
REQ-029 Reset asserted mid-sequence SHALL abandon the sequence; after release, operation SHALL restart from IDLE, with the first decision at the first rising edge.

Verification
REQ-030 Default parameters, left held for 25 cycles: left_signal SHALL show 000 x1, 001 x3, 011 x3, 111 x3, repeating; right_signal SHALL stay 000.
REQ-031 LAMPS=4, DWELL=2, right held: right_signal SHALL show 0000 x1, 1000 x2, 1100 x2, 1110 x2, 1111 x2, then 0000.
REQ-032 Left held, then right also asserted mid step 1: no change SHALL occur until the step-1 boundary; then error=1 with lamps 000. Releasing right SHALL give IDLE on the next cycle.
REQ-033 hazard pulsed during LEFT step 2, then held:
- outputs SHALL switch at the step-2 boundary to both sides 111 x3, then 000 x3, alternating.
- dropping hazard SHALL give IDLE at the next phase end.
REQ-034 reset_n driven low asynchronously during RIGHT step 3: outputs SHALL go 000/000 with error=0 before the next clk edge. Release with no requests held SHALL keep IDLE.
